// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: bundle between the game/score logic and the scan
// controller. The master side supplies display data and brightness; the
// slave side (the controller) returns the pin-level segment/anode drive and
// the end-of-frame pulse.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8,
    parameter int PWM_BITS   = 4
);
    logic [4*NUM_DIGITS-1:0] digits_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [NUM_DIGITS-1:0]   blank_i;
    logic [NUM_DIGITS-1:0]   blink_i;
    logic [PWM_BITS-1:0]     brightness;
    logic                    update;
    logic [7:0]              segment;
    logic [NUM_DIGITS-1:0]   enable;
    logic                    frame_done;

    modport master (
        output digits_i, dp_i, blank_i, blink_i, brightness, update,
        input  segment, enable, frame_done
    );

    modport slave (
        input  digits_i, dp_i, blank_i, blink_i, brightness, update,
        output segment, enable, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed common-anode 7-segment scan controller.
// - Scans NUM_DIGITS digits, DWELL_CYCLES nclk each; the first cycle of every
//   dwell is blanked so the previous digit's pattern never ghosts onto the next.
// - Display data goes through a shadow stage and only reaches the active
//   registers at the last cycle of a frame, so a frame is never torn.
// - Global PWM brightness, per-digit blank/blink/dp, full hex decode.
// - Optional build macro SEG7_LEADING_ZERO_BLANK_EN: suppresses leading zero
//   digits (digit 0 always shown). Without it every digit is displayed.
// segment/enable/frame_done are registered: one nclk after the scan state.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_CYCLES = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int PWM_BITS     = 4
) (
    input  logic              nclk,
    input  logic              rst_n,
    seg7_scan_ctrl_if.slave   bus
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DWELL_W = $clog2(DWELL_CYCLES);
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
    localparam logic [DWELL_W-1:0]    DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [DWELL_W-1:0]    DWELL_ONE  = DWELL_W'(1);
    localparam logic [DWELL_W-1:0]    DWELL_ZERO = DWELL_W'(0);
    localparam logic [FRAME_W-1:0]    FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
    localparam logic [FRAME_W-1:0]    FRAME_ONE  = FRAME_W'(1);
    localparam logic [PWM_BITS-1:0]   PWM_ONE    = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0]   PWM_FULL   = {PWM_BITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] EN_ONE     = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] EN_OFF     = {NUM_DIGITS{1'b1}};

    // Hex digit to active-low abcdefg pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Scan / timing state
    logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
    logic [DWELL_W-1:0]      dwell_q,    dwell_d;
    logic [PWM_BITS-1:0]     pwm_q,      pwm_d;
    logic [FRAME_W-1:0]      frame_q,    frame_d;
    logic                    phase_q,    phase_d;

    // Shadow and active display data
    logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q,     sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q,  sh_blank_d;
    logic [NUM_DIGITS-1:0]   sh_blink_q,  sh_blink_d;
    logic                    pending_q,   pending_d;
    logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0]   act_dp_q,     act_dp_d;
    logic [NUM_DIGITS-1:0]   act_blank_q,  act_blank_d;
    logic [NUM_DIGITS-1:0]   act_blink_q,  act_blink_d;

    // Registered outputs
    logic [7:0]              segment_q,    segment_d;
    logic [NUM_DIGITS-1:0]   enable_q,     enable_d;
    logic                    frame_done_q, frame_done_d;

    logic                    dwell_last_s;
    logic                    boundary_s;
    logic [NUM_DIGITS-1:0]   supp_s;
    logic [3:0]              sel_val_s;
    logic                    pwm_ok_s;
    logic                    dark_s;
    logic                    lit_s;

    // Scan counters, blink timing and shadow-to-active transfer.
    always_comb begin
        dwell_last_s = (dwell_q == DWELL_LAST);
        boundary_s   = dwell_last_s && (scan_idx_q == IDX_LAST);
        pwm_d        = pwm_q + PWM_ONE;
        frame_done_d = boundary_s;

        if (dwell_last_s) begin
            dwell_d = DWELL_ZERO;
            if (scan_idx_q == IDX_LAST) begin
                scan_idx_d = '0;
            end else begin
                scan_idx_d = scan_idx_q + IDX_ONE;
            end
        end else begin
            dwell_d    = dwell_q + DWELL_ONE;
            scan_idx_d = scan_idx_q;
        end

        if (boundary_s) begin
            if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FRAME_ONE;
                phase_d = phase_q;
            end
        end else begin
            frame_d = frame_q;
            phase_d = phase_q;
        end

        // Last update wins; an update on the boundary cycle is itself copied.
        if (bus.update) begin
            sh_digits_d = bus.digits_i;
            sh_dp_d     = bus.dp_i;
            sh_blank_d  = bus.blank_i;
            sh_blink_d  = bus.blink_i;
            pending_d   = 1'b1;
        end else begin
            sh_digits_d = sh_digits_q;
            sh_dp_d     = sh_dp_q;
            sh_blank_d  = sh_blank_q;
            sh_blink_d  = sh_blink_q;
            pending_d   = pending_q;
        end

        if (boundary_s && pending_d) begin
            act_digits_d = sh_digits_d;
            act_dp_d     = sh_dp_d;
            act_blank_d  = sh_blank_d;
            act_blink_d  = sh_blink_d;
            pending_d    = 1'b0;
        end else begin
            act_digits_d = act_digits_q;
            act_dp_d     = act_dp_q;
            act_blank_d  = act_blank_q;
            act_blink_d  = act_blink_q;
        end
    end

    // Leading-zero suppression mask, derived from the active data only.
    always_comb begin
        supp_s = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        begin : lzb
            logic chain;
            chain = 1'b1;
            for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                chain     = chain && (act_digits_q[4*k +: 4] == 4'h0) && !act_dp_q[k];
                supp_s[k] = chain;
            end
        end
`else
        supp_s = '0;
`endif
    end

    // Segment/anode drive for the selected digit, anti-ghost first cycle.
    always_comb begin
        sel_val_s = act_digits_q[{scan_idx_q, 2'b00} +: 4];
        pwm_ok_s  = (bus.brightness == PWM_FULL) || (pwm_q < bus.brightness);
        dark_s    = act_blank_q[scan_idx_q] || supp_s[scan_idx_q] ||
                    (act_blink_q[scan_idx_q] && phase_q);
        lit_s     = (dwell_q != DWELL_ZERO) && !dark_s && pwm_ok_s;
        if (lit_s) begin
            segment_d = {hex_to_seg(sel_val_s), ~act_dp_q[scan_idx_q]};
            enable_d  = ~(EN_ONE << scan_idx_q);
        end else begin
            segment_d = 8'hFF;
            enable_d  = EN_OFF;
        end
    end

    // State and output registers; reset darkens the display immediately.
    always_ff @(posedge nclk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx_q   <= '0;
            dwell_q      <= '0;
            pwm_q        <= '0;
            frame_q      <= '0;
            phase_q      <= 1'b0;
            sh_digits_q  <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '1;
            sh_blink_q   <= '0;
            pending_q    <= 1'b0;
            act_digits_q <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            act_blink_q  <= '0;
            segment_q    <= 8'hFF;
            enable_q     <= EN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            scan_idx_q   <= scan_idx_d;
            dwell_q      <= dwell_d;
            pwm_q        <= pwm_d;
            frame_q      <= frame_d;
            phase_q      <= phase_d;
            sh_digits_q  <= sh_digits_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            sh_blink_q   <= sh_blink_d;
            pending_q    <= pending_d;
            act_digits_q <= act_digits_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            act_blink_q  <= act_blink_d;
            segment_q    <= segment_d;
            enable_q     <= enable_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.segment    = segment_q;
    assign bus.enable     = enable_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a reference model that
// derives the display from the cycle count since reset.
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;
    localparam int N  = 8;
    localparam int D  = 16;
    localparam int BF = 2;
    localparam int P  = 4;
    localparam int FR = N * D;

    logic nclk = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;

    seg7_scan_ctrl_if #(.NUM_DIGITS(N), .PWM_BITS(P)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS(N), .DWELL_CYCLES(D), .BLINK_FRAMES(BF), .PWM_BITS(P)
    ) dut (
        .nclk(nclk), .rst_n(rst_n), .bus(bus)
    );

    always #5 nclk = ~nclk;

    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            edges = 0;
    logic [4*N-1:0] m_dig, s_dig;
    logic [N-1:0]   m_dp, m_blank, m_blink, s_dp, s_blank, s_blink;
    bit             m_pend;
    logic [7:0]     exp_seg = 8'hFF;
    logic [N-1:0]   exp_en = '1;
    logic           exp_fd = 1'b0;

    always @(posedge nclk) begin : model
        int dwell, idx, frm, phase, hi;
        bit dark, pwm_ok;
        if (!rst_n) begin
            edges = 0;
            m_dig = '0; m_dp = '0; m_blank = '1; m_blink = '0;
            s_dig = '0; s_dp = '0; s_blank = '1; s_blink = '0;
            m_pend = 1'b0;
            exp_seg = 8'hFF; exp_en = '1; exp_fd = 1'b0;
        end else begin
            dwell = edges % D;
            idx   = (edges / D) % N;
            frm   = edges / FR;
            phase = (frm / BF) % 2;
            hi    = N - 1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            hi = 0;
            for (int k = 1; k < N; k++)
                if (m_dig[4*k +: 4] != 4'h0 || m_dp[k]) hi = k;
`endif
            dark   = m_blank[idx] || (m_blink[idx] && phase == 1) || (idx > hi);
            pwm_ok = (bus.brightness == 4'hF) || ((edges % 16) < int'(bus.brightness));
            if (dwell != 0 && !dark && pwm_ok) begin
                exp_seg = {seg_tab[m_dig[4*idx +: 4]], ~m_dp[idx]};
                exp_en  = ~(N'(1) << idx);
            end else begin
                exp_seg = 8'hFF;
                exp_en  = '1;
            end
            exp_fd = ((edges % FR) == FR - 1);
            if (bus.update) begin
                s_dig = bus.digits_i; s_dp = bus.dp_i; s_blank = bus.blank_i; s_blink = bus.blink_i;
                m_pend = 1'b1;
            end
            if ((edges % FR) == FR - 1 && m_pend) begin
                m_dig = s_dig; m_dp = s_dp; m_blank = s_blank; m_blink = s_blink;
                m_pend = 1'b0;
            end
            edges++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge nclk) begin : compare
        if (chk_en) begin
            if (!rst_n) begin
                check("rst_segment", bus.segment, 8'hFF);
                check("rst_enable", bus.enable, 8'hFF);
                check("rst_frame_done", bus.frame_done, 1'b0);
            end else begin
                check("segment", bus.segment, exp_seg);
                check("enable", bus.enable, exp_en);
                check("frame_done", bus.frame_done, exp_fd);
            end
        end
    end

    // ---------------- frame monitor ----------------
    int         frames_seen = 0;
    int         pos = 0, cur_lit = 0, cur_d0 = 0, last_lit = 0, last_d0 = 0;
    int         cyc = 0, prev_fd = 0, last_gap = 0, saw_one = 0;
    bit         fd_valid = 1'b0;
    logic [7:0] cur_seg [FR];
    logic [N-1:0] cur_en [FR];
    logic [7:0] last_seg [FR];
    logic [N-1:0] last_en [FR];

    always @(negedge nclk) begin : monitor
        if (!rst_n) begin
            pos = 0; cur_lit = 0; cur_d0 = 0; fd_valid = 1'b0;
        end else if (edges > 0) begin
            cyc++;
            if (pos < FR) begin
                cur_seg[pos] = bus.segment;
                cur_en[pos]  = bus.enable;
            end
            pos++;
            if (bus.enable != '1) cur_lit++;
            if (!bus.enable[0]) cur_d0++;
            if (bus.enable == 8'hFE && bus.segment == 8'h9F) saw_one++;
            if (bus.frame_done) begin
                last_lit = cur_lit; last_d0 = cur_d0;
                for (int i = 0; i < FR; i++) begin
                    last_seg[i] = cur_seg[i];
                    last_en[i]  = cur_en[i];
                end
                if (fd_valid) last_gap = cyc - prev_fd;
                prev_fd = cyc; fd_valid = 1'b1;
                cur_lit = 0; cur_d0 = 0; pos = 0;
                frames_seen++;
            end
        end
    end

    task automatic wait_frames(input int n);
        int target, c;
        target = frames_seen + n;
        c = 0;
        while (frames_seen < target && c < n * FR + 64) begin
            @(posedge nclk);
            c++;
        end
        check("frame_wait", (frames_seen >= target), 1'b1);
        @(negedge nclk);
    endtask

    task automatic do_update(input logic [31:0] dig, input logic [7:0] dp,
                             input logic [7:0] blank, input logic [7:0] blink);
        bus.digits_i = dig; bus.dp_i = dp; bus.blank_i = blank; bus.blink_i = blink;
        bus.update = 1'b1;
        @(negedge nclk);
        bus.update = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int snap;
        int exp_d0 [6];
        bus.digits_i = '0; bus.dp_i = '0; bus.blank_i = '0; bus.blink_i = '0;
        bus.brightness = 4'hF; bus.update = 1'b0;
        exp_d0 = '{0, 15, 0, 0, 15, 15};

        // 1. reset, no update: dark, frame_done every 128 cycles
        repeat (3) @(negedge nclk);
        chk_en = 1'b1;
        check("reset_segment", bus.segment, 8'hFF);
        check("reset_enable", bus.enable, 8'hFF);
        rst_n = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_frames(1);
            check("dark_before_update", last_lit, 0);
        end
        check("frame_period", last_gap, 128);

        // 2. first update only takes effect at the frame boundary
        do_update(32'h8123_ABCD, 8'h00, 8'h00, 8'h00);
        wait_frames(1);
        check("no_change_before_boundary", last_lit, 0);
        wait_frames(1);
        check("digit0_segment", last_seg[1], 8'h85);
        check("digit0_enable", last_en[1], 8'hFE);
        check("digit3_segment", last_seg[3*D + 1], 8'h11);
        check("digit3_enable", last_en[3*D + 1], 8'hF7);
        for (int d = 0; d < N; d++) check("antighost_enable", last_en[d*D], 8'hFF);
        check("antighost_segment", last_seg[0], 8'hFF);
        check("full_bright_lit", last_lit, N * (D - 1));

        // 3. two updates within one frame: last one wins
        snap = saw_one;
        do_update(32'h8123_ABC1, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge nclk);
        do_update(32'h8123_ABC2, 8'h00, 8'h00, 8'h00);
        wait_frames(1);
        wait_frames(1);
        check("last_update_wins", last_seg[1], 8'h25);
        check("value1_never_shown", saw_one - snap, 0);

        // 4. PWM brightness
        bus.brightness = 4'h4;
        wait_frames(1);
        wait_frames(1);
        check("pwm_quarter_lit", last_lit, 3 * N);
        bus.brightness = 4'h0;
        wait_frames(1);
        wait_frames(1);
        check("pwm_zero_dark", last_lit, 0);
        bus.brightness = 4'hF;

        // 5. asynchronous reset mid-dwell, then blink
        @(posedge nclk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_enable", bus.enable, 8'hFF);
        check("async_rst_segment", bus.segment, 8'hFF);
        repeat (2) @(negedge nclk);
        rst_n = 1'b1;
        do_update(32'h7654_3210, 8'h00, 8'h00, 8'h01);
        for (int f = 0; f < 6; f++) begin
            wait_frames(1);
            check("blink_digit0", last_d0, exp_d0[f]);
            if (f > 0) check("blink_others", last_lit - last_d0, (N - 1) * (D - 1));
        end

        // 6. leading zeros
        do_update(32'h0000_0100, 8'h00, 8'h00, 8'h00);
        wait_frames(1);
        wait_frames(1);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check("lzb_lit", last_lit, 3 * (D - 1));
        check("lzb_digit3_dark", last_en[3*D + 5], 8'hFF);
`else
        check("lzb_lit", last_lit, N * (D - 1));
        check("lzb_digit3_shown", last_en[3*D + 5], 8'hF7);
`endif
        do_update(32'h0000_0100, 8'h10, 8'h00, 8'h00);
        wait_frames(1);
        wait_frames(1);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check("lzb_dp_relight", last_lit, 5 * (D - 1));
`else
        check("lzb_dp_relight", last_lit, N * (D - 1));
`endif

        // 7. randomized traffic, model checked every cycle
        for (int c = 0; c < 40 * FR; c++) begin
            @(negedge nclk);
            bus.update = ($urandom_range(0, 19) == 0);
            if (bus.update) begin
                bus.digits_i = $urandom >> (4 * $urandom_range(0, 7));
                bus.dp_i     = 8'($urandom & $urandom & $urandom);
                bus.blank_i  = 8'($urandom & $urandom & $urandom);
                bus.blink_i  = 8'($urandom & $urandom);
            end
            if ($urandom_range(0, 199) == 0) bus.brightness = 4'($urandom);
            rst_n = ($urandom_range(0, 2999) != 0);
        end
        @(negedge nclk);
        bus.update = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge nclk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
